// File: rtl/jtkiwi_colmix.sv
// jtkiwi_colmix: tilemap/object priority mix, 512x16 palette lookup and blanked 5-5-5 RGB output.
module jtkiwi_colmix #(
  parameter             SIMFILE = "",
  parameter logic [3:0] TRANSP  = 4'h0
) (
  input  logic       rst,
  input  logic       clk,
  input  logic       pxl_cen,
  input  logic       LHBL,
  input  logic       LVBL,
  input  logic [9:0] cpu_addr,
  input  logic [7:0] cpu_dout,
  input  logic       cpu_rnw,
  input  logic       pal_cs,
  output logic [7:0] cpu_din,
  input  logic [8:0] scr_pxl,
  input  logic [8:0] obj_pxl,
  input  logic [1:0] gfx_en,
  output logic [4:0] red,
  output logic [4:0] green,
  output logic [4:0] blue,
  output logic       LHBL_dly,
  output logic       LVBL_dly
);
  logic [15:0] pal[512];
  logic [8:0]  pal_addr;
  logic [8:0]  mix;
  logic [14:0] vid_data;
  logic [1:0]  blank1;
  logic        rd_en;
  logic        obj_opaque;
  always_comb obj_opaque = obj_pxl[3:0] != TRANSP && gfx_en[1];
  // a transparent tilemap pixel still indexes its pen-0 entry, acting as backdrop
  always_comb mix = obj_opaque ? obj_pxl : gfx_en[0] ? scr_pxl : 9'd0;
  // video port reads once, on the clk after each pixel, so collisions resolve read-before-write
  always_ff @(posedge clk) begin
    if (pal_cs && !cpu_rnw) begin
      if (cpu_addr[0]) pal[cpu_addr[9:1]][15:8] <= cpu_dout;
      else pal[cpu_addr[9:1]][7:0] <= cpu_dout;
    end
    if (rd_en) vid_data <= pal[pal_addr][14:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_din  <= 8'd0;
      pal_addr <= 9'd0;
      blank1   <= 2'd0;
      rd_en    <= 1'b0;
      {red, green, blue}   <= 15'd0;
      {LHBL_dly, LVBL_dly} <= 2'd0;
    end else begin
      rd_en <= pxl_cen;
      if (pal_cs) cpu_din <= cpu_addr[0] ? pal[cpu_addr[9:1]][15:8] : pal[cpu_addr[9:1]][7:0];
      if (pxl_cen) begin
        pal_addr <= mix;
        blank1   <= {LHBL, LVBL};
        {red, green, blue}   <= &blank1 ? vid_data : 15'd0;
        {LHBL_dly, LVBL_dly} <= blank1;
      end
    end
  end
endmodule

// File: tb/tb_jtkiwi_colmix.sv
// tb_jtkiwi_colmix: directed checks of palette CPU access, layer mixing, blanking, collision and reset.
module tb_jtkiwi_colmix;
  logic       rst = 1, clk = 0, pxl_cen = 0, LHBL = 1, LVBL = 1;
  logic [9:0] cpu_addr = 0;
  logic [7:0] cpu_dout = 0, cpu_din;
  logic       cpu_rnw = 1, pal_cs = 0;
  logic [8:0] scr_pxl = 0, obj_pxl = 0;
  logic [1:0] gfx_en = 0;
  logic [4:0] red, green, blue;
  logic       LHBL_dly, LVBL_dly;
  int total = 0, bad = 0;

  jtkiwi_colmix dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .LHBL(LHBL), .LVBL(LVBL),
    .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rnw(cpu_rnw), .pal_cs(pal_cs),
    .cpu_din(cpu_din), .scr_pxl(scr_pxl), .obj_pxl(obj_pxl), .gfx_en(gfx_en),
    .red(red), .green(green), .blue(blue), .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [7:0] d);
    cpu_addr = a; cpu_dout = d; cpu_rnw = 0; pal_cs = 1;
    tick;
    pal_cs = 0; cpu_rnw = 1;
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [7:0] exp);
    cpu_addr = a; cpu_rnw = 1; pal_cs = 1;
    tick;
    chk(tag, cpu_din, exp);
    pal_cs = 0;
  endtask

  task automatic pix(input logic [8:0] s, input logic [8:0] o, input logic [1:0] g, input logic h, input logic v);
    scr_pxl = s; obj_pxl = o; gfx_en = g; LHBL = h; LVBL = v; pxl_cen = 1;
    tick;
    pxl_cen = 0;
    tick; tick; tick;
  endtask

  logic [8:0]  sv[9] = '{9'h012, 9'h012, 9'h012, 9'h012, 9'h012, 9'h012, 9'h012, 9'h012, 9'h012};
  logic [8:0]  ov[9] = '{9'h1A3, 9'h1A0, 9'h1A3, 9'h1A3, 9'h055, 9'h050, 9'h1A3, 9'h1A0, 9'h1A3};
  logic [1:0]  gv[9] = '{2'd3, 2'd3, 2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  logic        hv[9] = '{1, 1, 1, 1, 1, 1, 0, 1, 1};
  logic        vv[9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [14:0] ev[9] = '{15'h03E0, 15'h7C1F, 15'h7C1F, 15'h1234, 15'h7FFF, 15'h1234, 15'h0000, 15'h7C1F, 15'h0000};

  initial begin
    #12;
    chk("rst_rgb", {red, green, blue}, 0);
    chk("rst_hbl", LHBL_dly, 0);
    chk("rst_vbl", LVBL_dly, 0);
    chk("rst_din", cpu_din, 0);
    rst = 0;
    tick;
    wr(10'h024, 8'h1F); wr(10'h025, 8'h7C);
    rd("rd_lo", 10'h024, 8'h1F);
    rd("rd_hi", 10'h025, 8'h7C);
    cpu_addr = 10'h024;
    tick;
    chk("din_hold", cpu_din, 8'h7C);
    wr(10'h346, 8'hE0); wr(10'h347, 8'h03);
    wr(10'h000, 8'h34); wr(10'h001, 8'h12);
    wr(10'h0AA, 8'hFF); wr(10'h0AB, 8'hFF);
    rd("rd_e0", 10'h001, 8'h12);
    for (int i = 0; i < 9; i++) begin
      pix(sv[i], ov[i], gv[i], hv[i], vv[i]);
      if (i > 0) begin
        chk($sformatf("rgb%0d", i - 1), {red, green, blue}, ev[i - 1]);
        chk($sformatf("hbl%0d", i - 1), LHBL_dly, hv[i - 1]);
        chk($sformatf("vbl%0d", i - 1), LVBL_dly, vv[i - 1]);
      end
    end
    pix(9'h012, 9'h1A0, 2'd3, 1, 1);
    chk("rgb8", {red, green, blue}, ev[8]);
    chk("vbl8", LVBL_dly, 0);
    // CPU rewrites entry 0x012 on the very clk the video port reads it
    scr_pxl = 9'h012; obj_pxl = 9'h1A0; gfx_en = 2'd3; LHBL = 1; LVBL = 1; pxl_cen = 1;
    tick;
    pxl_cen = 0;
    wr(10'h024, 8'hE0);
    tick; tick;
    pix(9'h012, 9'h1A0, 2'd3, 1, 1);
    chk("coll_old", {red, green, blue}, 15'h7C1F);
    pix(9'h012, 9'h1A0, 2'd3, 1, 1);
    chk("coll_new", {red, green, blue}, 15'h7CE0);
    rd("rd_din", 10'h025, 8'h7C);
    #2 rst = 1;
    #1;
    chk("mid_rgb", {red, green, blue}, 0);
    chk("mid_hbl", LHBL_dly, 0);
    chk("mid_vbl", LVBL_dly, 0);
    chk("mid_din", cpu_din, 0);
    tick;
    rst = 0;
    pix(9'h012, 9'h1A0, 2'd3, 1, 1);
    chk("post1_rgb", {red, green, blue}, 0);
    chk("post1_hbl", LHBL_dly, 0);
    pix(9'h000, 9'h055, 2'd2, 1, 1);
    chk("post2_rgb", {red, green, blue}, 15'h7CE0);
    chk("post2_hbl", LHBL_dly, 1);
    pix(9'h000, 9'h000, 2'd0, 1, 1);
    chk("post3_rgb", {red, green, blue}, 15'h7FFF);
    pix(9'h000, 9'h000, 2'd0, 1, 1);
    chk("post4_rgb", {red, green, blue}, 15'h1234);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtkiwi_colmix.md
Name: jtkiwi_colmix

Overview:
Colour mixer and palette stage directly downstream of the Kiwi GFX block.
- Takes the 9-bit tilemap pixel (scr_pxl) and the 9-bit object pixel (obj_pxl) produced each pixel clock.
- Resolves layer priority and transparency, then looks the result up in a CPU-writable 512x16 palette RAM.
- Emits blanked 5-5-5 RGB with delayed LHBL/LVBL aligned to the colour data, ready for the video output/scan-doubler.

Parameters:
SIMFILE, "", optional palette RAM initialisation file for simulation.
TRANSP, 4'h0, pen value in pxl[3:0] treated as transparent.

Ports:
rst  input  1  asynchronous reset, active high
clk  input  1  single system clock; the CPU and video ports of the palette both run on it
pxl_cen  input  1  pixel clock enable; consecutive pulses are at least 2 clk apart
LHBL  input  1  horizontal blank, active low, aligned with the pixel inputs
LVBL  input  1  vertical blank, active low, aligned with the pixel inputs
cpu_addr  input  10  CPU byte address in palette space
cpu_dout  input  8  CPU write data
cpu_rnw  input  1  1 = read, 0 = write
pal_cs  input  1  palette chip select
cpu_din  output  8  palette read data to the CPU
scr_pxl  input  9  tilemap pixel: {palette[4:0], pen[3:0]}
obj_pxl  input  9  object pixel: same format as scr_pxl
gfx_en  input  2  layer enables: bit0 = tilemap, bit1 = objects
red  output  5  red component
green  output  5  green component
blue  output  5  blue component
LHBL_dly  output  1  LHBL delayed to match the RGB outputs
LVBL_dly  output  1  LVBL delayed to match the RGB outputs

Behaviour:
Reset:
- Asynchronous, active high.
- red, green, blue, LHBL_dly, LVBL_dly, cpu_din, the internal pal_addr and both blank pipe stages all go to 0.
- Palette contents are not cleared.
- Reset asserted mid-frame takes effect immediately. After release, the outputs stay 0 until two pxl_cen pulses have passed.

Palette RAM:
- 512 entries x 16 bits, dual port, both ports on clk.
- Entry format: bit15 unused; [14:10] R; [9:5] G; [4:0] B.

CPU port:
- Entry index = cpu_addr[9:1]; cpu_addr[0] = 0 selects the low byte, 1 the high byte.
- Write: when pal_cs & ~cpu_rnw, the selected byte is written on that clk edge. The other byte is untouched.
- Read: synchronous. cpu_din presents the selected byte one clk after the address is applied, using the registered cpu_addr[0].
- cpu_din holds its last value when pal_cs is low.

Pixel pipeline (all stages advance only on clk edges with pxl_cen=1):
- Stage 1, opacity:
  - obj is opaque when obj_pxl[3:0] != TRANSP and gfx_en[1] = 1.
  - pal_addr <= obj opaque ? obj_pxl : (gfx_en[0] ? scr_pxl : 9'd0).
  - A transparent scr pixel is still used; its pen-0 colour acts as the backdrop.
  - blank pipe stage 1 <= {LHBL, LVBL}.
- RAM read: port B samples pal_addr on the next clk; data is valid before the next pxl_cen.
- Stage 2: if stage-1 LHBL & LVBL are both 1, {red, green, blue} <= RAM data [14:0]; otherwise all three <= 0. {LHBL_dly, LVBL_dly} <= blank stage 1.
- Latency: exactly 2 pxl_cen pulses from pixel input to RGB out; the blank signals get the same 2-pulse delay.
- Outputs hold their value between pxl_cen pulses.

Collision:
- If a CPU write and the video read hit the same entry on the same clk, the video side gets the old data (read-before-write).
- The new value appears on the following read.
- The CPU side is never stalled.

Widths:
- No arithmetic; pure selection.
- gfx_en = 2'b00 forces palette index 0 for every pixel.

Test Plan:
- Write entry 9'h012 = 16'h7C1F via byte address 10'h024 (0x1F) and 10'h025 (0x7C), then read both bytes back -> cpu_din = 0x1F then 0x7C, each one clk after its address.
- Entries 0x012 = 0x7C1F and 0x1A3 = 0x03E0; scr_pxl = 0x012, obj_pxl = 0x1A3, gfx_en = 3, blanks high -> after 2 pxl_cen: red = 0, green = 31, blue = 0. With obj_pxl = 0x1A0 (transparent) -> red = 31, green = 0, blue = 31.
- Same stimulus with gfx_en = 2'b01 -> obj ignored, scr colour shown. With gfx_en = 2'b00 -> entry 0 colour shown.
- LHBL driven low for one pixel -> RGB = 0 and LHBL_dly low for exactly one pixel, both starting 2 pxl_cen after the input.
- CPU writes entry 0x012 on the same clk the video reads it -> that pixel shows the old colour, the next pixel shows the new one.
- Assert rst mid-line -> all outputs 0 immediately. After release, RGB stays 0 for 2 pxl_cen, then follows the inputs. Palette contents are retained.
